frame_sched: RTL and testbench



---
 rtl/frame_sched_pkg.sv | 34 +++
 rtl/frame_sched_sync_axis.sv | 57 +++++
 rtl/frame_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_frame_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// rtl/frame_sched_pkg.sv - shared types and default timing for the frame scheduler
//
// Contents:
//   COORD_W        width of the raster coordinates (10 bits)
//   DEF_*          default VGA 640x480 timing (pixel clocks / lines)
//   arb_state_t    host-configuration arbiter states
//   axis_total()   sum of active, porches and sync for one raster axis
package frame_sched_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_COMMIT = 2'd2,
        ARB_ABORT  = 2'd3
    } arb_state_t;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/frame_sched_sync_axis.sv
// rtl/frame_sched_sync_axis.sv - one raster axis: wrapping counter with sync and active windows
//
// Ports:
//   clk, rst   pixel clock, asynchronous active-high reset
//   i_en       advance the counter this cycle
//   o_cnt      current count, 0..TOTAL-1
//   o_last     count is TOTAL-1 (next enabled cycle wraps to 0)
//   o_sync_n   low while the count lies inside the sync pulse window
//   o_active   high while the count lies inside the visible region
// All outputs are combinational decodes of the count register; the top registers them.
module frame_sched_sync_axis
    import frame_sched_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    output logic [COORD_W-1:0] o_cnt,
    output logic               o_last,
    output logic               o_sync_n,
    output logic               o_active
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [COORD_W-1:0] C_LAST       = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] C_ACTIVE     = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] C_SYNC_START = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] C_SYNC_END   = COORD_W'(ACTIVE + FP + SYNC);

    logic [COORD_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_cnt    = r_cnt;
    assign o_last   = w_last;
    assign o_sync_n = !((r_cnt >= C_SYNC_START) && (r_cnt < C_SYNC_END));
    assign o_active = (r_cnt < C_ACTIVE);

endmodule

// File: rtl/frame_sched.sv
// rtl/frame_sched.sv - VGA raster generator and vblank-only host config arbiter
//
// Build option: define FRAME_SCHED_OVERRUN_EN to get a sticky overrun flag that
// records a grant aborted at the end of a frame; otherwise overrun is tied 0.
//
// Ports:
//   clk, rst     pixel clock, asynchronous active-high reset
//   host_req     host wants a config window (level, held until host_done)
//   host_done    one-cycle pulse, host finished writing shadow config
//   host_grant   host may write shadow config while high
//   commit       one-cycle pulse, renderer copies shadow into live config
//   frame_start  one-cycle pulse at pixel (0,0)
//   px_valid     current coordinate is visible
//   px_x, px_y   current column / line
//   hsync, vsync active-low sync pulses
//   overrun      sticky grant-abort flag (option above)
// Raster outputs are registered and lag the internal counters by one cycle.
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_req,
    input  logic               host_done,
    output logic               host_grant,
    output logic               commit,
    output logic               frame_start,
    output logic               px_valid,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic               hsync,
    output logic               vsync,
    output logic               overrun
);

    // Counters hold at (0,0) for the first cycle after reset so that the
    // registered outputs show (0,0) with frame_start on the second edge.
    logic r_run;

    logic [COORD_W-1:0] w_h_cnt;
    logic [COORD_W-1:0] w_v_cnt;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_h_sync_n;
    logic               w_v_sync_n;
    logic               w_h_active;
    logic               w_v_active;
    logic               w_v_en;
    logic               w_vblank;
    logic               w_frame_last;
    logic               w_origin;

    logic [COORD_W-1:0] r_px_x;
    logic [COORD_W-1:0] r_px_y;
    logic               r_px_valid;
    logic               r_frame_start;
    logic               r_hsync;
    logic               r_vsync;

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_armed;
    logic       w_enter_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_v_en = r_run && w_h_last;

    frame_sched_sync_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_run),
        .o_cnt    (w_h_cnt),
        .o_last   (w_h_last),
        .o_sync_n (w_h_sync_n),
        .o_active (w_h_active)
    );

    frame_sched_sync_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_v_en),
        .o_cnt    (w_v_cnt),
        .o_last   (w_v_last),
        .o_sync_n (w_v_sync_n),
        .o_active (w_v_active)
    );

    assign w_vblank     = !w_v_active;
    assign w_frame_last = w_h_last && w_v_last;
    assign w_origin     = (w_h_cnt == '0) && (w_v_cnt == '0);

    // Raster output stage: everything sampled from the same counter state so
    // coordinates, syncs, px_valid and frame_start stay mutually aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_px_x        <= '0;
            r_px_y        <= '0;
            r_px_valid    <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
        end else if (r_run) begin
            r_px_x        <= w_h_cnt;
            r_px_y        <= w_v_cnt;
            r_px_valid    <= w_h_active && w_v_active;
            r_frame_start <= w_origin;
            r_hsync       <= w_h_sync_n;
            r_vsync       <= w_v_sync_n;
        end
    end

    assign px_x        = r_px_x;
    assign px_y        = r_px_y;
    assign px_valid    = r_px_valid;
    assign frame_start = r_frame_start;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;

    // Arbiter: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbiter: next state. A grant is never opened on the last cycle of the
    // frame because it would have to abort immediately.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (host_req && r_armed && w_vblank && !w_frame_last) begin
                    w_state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (host_done) begin
                    w_state_nxt = ARB_COMMIT;
                end else if (w_frame_last) begin
                    w_state_nxt = ARB_ABORT;
                end
            end
            ARB_COMMIT: w_state_nxt = ARB_IDLE;
            ARB_ABORT:  w_state_nxt = ARB_IDLE;
            default:    w_state_nxt = ARB_IDLE;
        endcase
    end

    // Arbiter: outputs decoded from the state register
    always_comb begin
        host_grant = 1'b0;
        commit     = 1'b0;
        case (r_state)
            ARB_GRANT:  host_grant = 1'b1;
            ARB_COMMIT: commit     = 1'b1;
            default: begin
                host_grant = 1'b0;
                commit     = 1'b0;
            end
        endcase
    end

    assign w_enter_grant = (r_state == ARB_IDLE) && (w_state_nxt == ARB_GRANT);

    // One grant per request: the host must drop host_req before it can be
    // granted again, so a level held high after commit cannot re-open a window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b1;
        end else if (w_enter_grant) begin
            r_armed <= 1'b0;
        end else if (!host_req) begin
            r_armed <= 1'b1;
        end
    end

`ifdef FRAME_SCHED_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if ((r_state == ARB_GRANT) && (w_state_nxt == ARB_ABORT)) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sched.sv
// tb/tb_frame_sched.sv - randomized self-checking bench for frame_sched
module tb_frame_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_req = 1'b0;
    logic host_done = 1'b0;

    logic       g0, c0, fs0, v0, hs0, vs0, o0;
    logic [9:0] x0, y0;
    logic       g1, c1, fs1, v1, hs1, vs1, o1;
    logic [9:0] x1, y1;

    always #5 clk = ~clk;

    frame_sched u_dut (
        .clk(clk), .rst(rst), .host_req(host_req), .host_done(host_done),
        .host_grant(g0), .commit(c0), .frame_start(fs0), .px_valid(v0),
        .px_x(x0), .px_y(y0), .hsync(hs0), .vsync(vs0), .overrun(o0)
    );

    frame_sched #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk(clk), .rst(rst), .host_req(host_req), .host_done(host_done),
        .host_grant(g1), .commit(c1), .frame_start(fs1), .px_valid(v1),
        .px_x(x1), .px_y(y1), .hsync(hs1), .vsync(vs1), .overrun(o1)
    );

`ifdef FRAME_SCHED_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    // timing of both instances
    int m_ha[2]  = '{640, 8};
    int m_hfp[2] = '{16, 2};
    int m_hsw[2] = '{96, 3};
    int m_hbp[2] = '{48, 2};
    int m_va[2]  = '{480, 6};
    int m_vfp[2] = '{10, 1};
    int m_vsw[2] = '{2, 2};
    int m_vbp[2] = '{33, 2};

    // model: t = clock edges since reset release; phase 0 idle,1 grant,2 commit,3 abort
    int t = 0;
    int ph[2];
    bit armed[2];
    bit ovr[2];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int htot(input int i);
        return m_ha[i] + m_hfp[i] + m_hsw[i] + m_hbp[i];
    endfunction

    function automatic int vtot(input int i);
        return m_va[i] + m_vfp[i] + m_vsw[i] + m_vbp[i];
    endfunction

    // raster position the internal counters hold before edge number e
    function automatic int cnt_pos(input int i, input int e);
        if (e < 2) return 0;
        return (e - 2) % (htot(i) * vtot(i));
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0;
            armed[i] = 1'b1;
            ovr[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            t = t + 1;
            for (int i = 0; i < 2; i++) begin
                int pos, ch, cv, nph;
                bit last, vbl, enter;
                pos = cnt_pos(i, t);
                ch = pos % htot(i);
                cv = pos / htot(i);
                last = (ch == htot(i) - 1) && (cv == vtot(i) - 1);
                vbl = (cv >= m_va[i]);
                enter = 1'b0;
                nph = ph[i];
                if (ph[i] == 0) begin
                    if (host_req && armed[i] && vbl && !last) begin
                        nph = 1;
                        enter = 1'b1;
                    end
                end else if (ph[i] == 1) begin
                    if (host_done) nph = 2;
                    else if (last) begin
                        nph = 3;
                        if (OVR_EN) ovr[i] = 1'b1;
                    end
                end else begin
                    nph = 0;
                end
                if (enter) armed[i] = 1'b0;
                else if (!host_req) armed[i] = 1'b1;
                ph[i] = nph;
            end
        end
    endtask

    task automatic check(input string nm, input int i, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0d: got %0d expected %0d", nm, i, t, act, exp);
        end
    endtask

    task automatic compare_all();
        int a_x[2], a_y[2], a_v[2], a_fs[2], a_hs[2], a_vs[2], a_g[2], a_c[2], a_o[2];
        a_x = '{int'(x0), int'(x1)};
        a_y = '{int'(y0), int'(y1)};
        a_v = '{int'(v0), int'(v1)};
        a_fs = '{int'(fs0), int'(fs1)};
        a_hs = '{int'(hs0), int'(hs1)};
        a_vs = '{int'(vs0), int'(vs1)};
        a_g = '{int'(g0), int'(g1)};
        a_c = '{int'(c0), int'(c1)};
        a_o = '{int'(o0), int'(o1)};
        for (int i = 0; i < 2; i++) begin
            int ex, ey, ev, efs, ehs, evs, pos;
            if (t < 2) begin
                ex = 0; ey = 0; ev = 0; efs = 0; ehs = 1; evs = 1;
            end else begin
                pos = cnt_pos(i, t - 0) ;
                pos = (t - 2) % (htot(i) * vtot(i));
                ex = pos % htot(i);
                ey = pos / htot(i);
                ev = (ex < m_ha[i] && ey < m_va[i]) ? 1 : 0;
                efs = (pos == 0) ? 1 : 0;
                ehs = (ex >= m_ha[i] + m_hfp[i] && ex < m_ha[i] + m_hfp[i] + m_hsw[i]) ? 0 : 1;
                evs = (ey >= m_va[i] + m_vfp[i] && ey < m_va[i] + m_vfp[i] + m_vsw[i]) ? 0 : 1;
            end
            check("px_x", i, a_x[i], ex);
            check("px_y", i, a_y[i], ey);
            check("px_valid", i, a_v[i], ev);
            check("frame_start", i, a_fs[i], efs);
            check("hsync", i, a_hs[i], ehs);
            check("vsync", i, a_vs[i], evs);
            check("host_grant", i, a_g[i], (ph[i] == 1) ? 1 : 0);
            check("commit", i, a_c[i], (ph[i] == 2) ? 1 : 0);
            check("overrun", i, a_o[i], int'(ovr[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_grant(input string nm);
        int k;
        for (k = 0; k < 400 && !g1; k++) step();
        check({nm, "_grant_timeout"}, 1, int'(g1), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_cnt, first_hs, val_cnt, fs_t0, fs_t1, vs_cnt, first_vs, grants, k;
        int frame1;
        frame1 = htot(1) * vtot(1);
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // raster: one default line and several small frames, no host activity
        hs_cnt = 0; first_hs = -1; val_cnt = 0; fs_t0 = -1; fs_t1 = -1;
        vs_cnt = 0; first_vs = -1;
        for (int c = 0; c < 1700; c++) begin
            step();
            if (t >= 2 && y0 == 0) begin
                if (!hs0) begin
                    hs_cnt++;
                    if (first_hs < 0) first_hs = x0;
                end
                if (v0) val_cnt++;
            end
            if (t >= 2 && t < 2 + frame1 && !vs1) begin
                vs_cnt++;
                if (first_vs < 0) first_vs = y1;
            end
            if (fs1) begin
                if (fs_t0 < 0) fs_t0 = t;
                else if (fs_t1 < 0) fs_t1 = t;
            end
        end
        check("hsync_low_cycles", 0, hs_cnt, 96);
        check("hsync_first_x", 0, first_hs, 656);
        check("valid_per_line", 0, val_cnt, 640);
        check("vsync_low_cycles", 1, vs_cnt, 30);
        check("vsync_first_y", 1, first_vs, 7);
        check("frame_period", 1, fs_t1 - fs_t0, 165);

        // request raised in the active region: grant waits for first vblank line
        for (k = 0; k < 400 && !(y1 == 2); k++) step();
        host_req = 1'b1;
        wait_grant("first");
        check("grant_at_y", 1, int'(y1), 6);
        check("grant_at_x", 1, int'(x1), 0);
        step();
        host_done = 1'b1;
        step();
        host_done = 1'b0;
        check("commit_pulse", 1, int'(c1), 1);
        check("grant_drop", 1, int'(g1), 0);

        // request held high: no second grant
        grants = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (g1) grants++;
        end
        check("no_regrant", 1, grants, 0);

        // host_done on the last frame cycle wins over abort
        host_req = 1'b0;
        step();
        step();
        host_req = 1'b1;
        wait_grant("last");
        for (k = 0; k < 400 && ((t - 1) % frame1) != frame1 - 1; k++) step();
        host_done = 1'b1;
        step();
        host_done = 1'b0;
        check("done_at_last_commit", 1, int'(c1), 1);

        // grant held past the end of frame aborts
        host_req = 1'b0;
        step();
        step();
        host_req = 1'b1;
        wait_grant("abort");
        for (k = 0; k < 400 && g1; k++) step();
        check("abort_no_commit", 1, int'(c1), 0);
        check("abort_overrun", 1, int'(o1), OVR_EN ? 1 : 0);

        // asynchronous reset in the middle of a grant
        host_req = 1'b0;
        step();
        step();
        host_req = 1'b1;
        wait_grant("rst");
        step();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_grant", 1, int'(g1), 0);
        check("rst_hsync", 1, int'(hs1), 1);
        check("rst_vsync", 1, int'(vs1), 1);
        host_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        check("restart_x", 1, int'(x1), 0);
        check("restart_y", 1, int'(y1), 0);
        check("restart_fs", 1, int'(fs1), 1);

        // random host traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            host_done = 1'b0;
            if ($urandom_range(0, 15) == 0) host_req = ~host_req;
            if (host_req && $urandom_range(0, 5) == 0) host_done = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
